// File: rtl/store_checker_pkg.sv
// Shared types for the store checker: FSM states and failure codes.
// Pure declarations; no logic, no latency, no flow control.
// Helper sizes index fields so a one-entry table still gets a 1-bit index.
package store_checker_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    PASS = 2'd2,
    FAIL = 2'd3
  } state_t;

  typedef enum logic [1:0] {
    FAIL_NONE     = 2'd0,
    FAIL_MISMATCH = 2'd1,
    FAIL_TIMEOUT  = 2'd2
  } fail_code_t;

  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/store_match_table.sv
// Expected-store table with match flags; lookup of one store per cycle (macro STORE_CHECKER_UNORDERED_EN).
// Lookup is combinational; flag and pointer updates take effect the next cycle.
// No backpressure: loads beyond capacity are dropped, stores are never stalled.
module store_match_table
  import store_checker_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int NUM_EXPECT = 4
) (
  input  logic                             clock,
  input  logic                             reset_n,
  input  logic                             load_en,
  input  logic [ADDR_WIDTH-1:0]            load_address,
  input  logic [DATA_WIDTH-1:0]            load_data,
  input  logic                             clear_flags,
  input  logic                             store_check,
  input  logic [ADDR_WIDTH-1:0]            store_address,
  input  logic [DATA_WIDTH-1:0]            store_data,
  input  logic                             ordered,
  input  logic [$clog2(NUM_EXPECT+1)-1:0]  match_index,
  output logic                             load_full,
  output logic [$clog2(NUM_EXPECT+1)-1:0]  load_count,
  output logic                             hit
);

  localparam int IW = idx_width(NUM_EXPECT);
  localparam int CW = $clog2(NUM_EXPECT + 1);

  logic [ADDR_WIDTH-1:0] addr_q [NUM_EXPECT];
  logic [DATA_WIDTH-1:0] data_q [NUM_EXPECT];
  logic [NUM_EXPECT-1:0] flag_q;
  logic [CW-1:0]         ptr_q;
  logic [IW-1:0]         hit_idx;
  logic                  ordered_hit;

  assign load_full  = (ptr_q == CW'(NUM_EXPECT));
  assign load_count = ptr_q;

  // In ordered mode the next entry to match is always entry[match_count].
  assign ordered_hit = (addr_q[IW'(match_index)] == store_address) &&
                       (data_q[IW'(match_index)] == store_data);

`ifdef STORE_CHECKER_UNORDERED_EN
  always_comb begin
    hit     = 1'b0;
    hit_idx = '0;
    if (ordered) begin
      hit     = ordered_hit;
      hit_idx = IW'(match_index);
    end else begin
      // Walk downwards so the lowest-index free match wins.
      for (int i = NUM_EXPECT - 1; i >= 0; i--) begin
        if ((CW'(i) < ptr_q) && !flag_q[i] &&
            (addr_q[i] == store_address) && (data_q[i] == store_data)) begin
          hit     = 1'b1;
          hit_idx = IW'(i);
        end
      end
    end
  end
`else
  logic unused_ordered;
  assign unused_ordered = ordered;
  assign hit     = ordered_hit;
  assign hit_idx = IW'(match_index);
`endif

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      ptr_q  <= '0;
      flag_q <= '0;
    end else begin
      if (load_en && !load_full) begin
        addr_q[IW'(ptr_q)] <= load_address;
        data_q[IW'(ptr_q)] <= load_data;
        ptr_q              <= ptr_q + 1'b1;
      end
      if (clear_flags) begin
        flag_q <= '0;
      end else if (store_check && hit) begin
        flag_q[hit_idx] <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/store_checker.sv
// Monitor matching core data-memory writes against an expected-store table (macro STORE_CHECKER_UNORDERED_EN).
// Verdict registered: PASS/FAIL visible the cycle after the deciding store or timeout cycle.
// No backpressure: observes the write port only and never stalls the core.
module store_checker
  import store_checker_pkg::*;
#(
  parameter int     DATA_WIDTH     = 32,
  parameter int     ADDR_WIDTH     = 32,
  parameter int     NUM_EXPECT     = 4,
  parameter int     TIMEOUT_CYCLES = 1000,
  parameter longint IGNORE_BASE    = 96,
  parameter longint IGNORE_LIMIT   = 96
) (
  input  logic                                 clock,
  input  logic                                 reset_n,
  input  logic                                 load_valid,
  input  logic [ADDR_WIDTH-1:0]                load_address,
  input  logic [DATA_WIDTH-1:0]                load_data,
  input  logic                                 start,
  input  logic                                 clear,
  input  logic                                 ordered,
  input  logic                                 memory_write_enable,
  input  logic [ADDR_WIDTH-1:0]                data_memory_address,
  input  logic [DATA_WIDTH-1:0]                write_data,
  output logic                                 load_full,
  output logic                                 busy,
  output logic                                 done,
  output logic                                 pass,
  output logic [1:0]                           fail_code,
  output logic [$clog2(NUM_EXPECT+1)-1:0]      match_count,
  output logic [$clog2(TIMEOUT_CYCLES+1)-1:0]  cycle_count,
  output logic [ADDR_WIDTH-1:0]                fail_address,
  output logic [DATA_WIDTH-1:0]                fail_data
);

  localparam int MW = $clog2(NUM_EXPECT + 1);
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam bit WINDOW_EN = (IGNORE_LIMIT >= IGNORE_BASE);
  localparam logic [ADDR_WIDTH-1:0] IGN_LO = ADDR_WIDTH'(IGNORE_BASE);
  localparam logic [ADDR_WIDTH-1:0] IGN_HI = ADDR_WIDTH'(IGNORE_LIMIT);

  state_t                state_q, state_d;
  fail_code_t            code_q, code_d;
  logic [MW-1:0]         match_q, match_d;
  logic [CW-1:0]         cycle_q, cycle_d;
  logic [ADDR_WIDTH-1:0] faddr_q, faddr_d;
  logic [DATA_WIDTH-1:0] fdata_q, fdata_d;
  logic                  mode_ordered;

  logic          ignored, store_check, hit, last_match, clear_any;
  logic [MW-1:0] load_count;
  logic [CW-1:0] cycle_inc;

  assign ignored = WINDOW_EN && (data_memory_address >= IGN_LO) &&
                   (data_memory_address <= IGN_HI);
  // A clear in the same cycle as a store wins, so that store is never checked.
  assign store_check = (state_q == RUN) && memory_write_enable && !ignored && !clear;
  assign clear_any   = clear && (state_q != IDLE);
  assign last_match  = hit && ((match_q + 1'b1) == load_count);
  assign cycle_inc   = (cycle_q == CW'(TIMEOUT_CYCLES)) ? cycle_q : cycle_q + 1'b1;

`ifdef STORE_CHECKER_UNORDERED_EN
  logic mode_q;
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      mode_q <= 1'b1;
    end else if (state_q == IDLE && start) begin
      mode_q <= ordered;
    end
  end
  assign mode_ordered = mode_q;
`else
  logic unused_ordered;
  assign unused_ordered = ordered;
  assign mode_ordered   = 1'b1;
`endif

  store_match_table #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH),
    .NUM_EXPECT (NUM_EXPECT)
  ) u_table (
    .clock         (clock),
    .reset_n       (reset_n),
    .load_en       ((state_q == IDLE) && load_valid && !start),
    .load_address  (load_address),
    .load_data     (load_data),
    .clear_flags   (clear_any),
    .store_check   (store_check),
    .store_address (data_memory_address),
    .store_data    (write_data),
    .ordered       (mode_ordered),
    .match_index   (match_q),
    .load_full     (load_full),
    .load_count    (load_count),
    .hit           (hit)
  );

  always_comb begin
    state_d = state_q;
    code_d  = code_q;
    match_d = match_q;
    cycle_d = cycle_q;
    faddr_d = faddr_q;
    fdata_d = fdata_q;
    if (clear_any) begin
      state_d = IDLE;
      code_d  = FAIL_NONE;
      match_d = '0;
      cycle_d = '0;
      faddr_d = '0;
      fdata_d = '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (start) begin
            state_d = (load_count == '0) ? PASS : RUN;
            cycle_d = '0;
          end
        end
        RUN: begin
          if (store_check && !hit) begin
            state_d = FAIL;
            code_d  = FAIL_MISMATCH;
            faddr_d = data_memory_address;
            fdata_d = write_data;
          end else if (store_check && last_match) begin
            // Final match beats a timeout landing in the same cycle.
            state_d = PASS;
            match_d = match_q + 1'b1;
          end else begin
            if (store_check) match_d = match_q + 1'b1;
            if (cycle_q == CW'(TIMEOUT_CYCLES - 1)) begin
              state_d = FAIL;
              code_d  = FAIL_TIMEOUT;
            end else begin
              cycle_d = cycle_inc;
            end
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q <= IDLE;
      code_q  <= FAIL_NONE;
      match_q <= '0;
      cycle_q <= '0;
      faddr_q <= '0;
      fdata_q <= '0;
    end else begin
      state_q <= state_d;
      code_q  <= code_d;
      match_q <= match_d;
      cycle_q <= cycle_d;
      faddr_q <= faddr_d;
      fdata_q <= fdata_d;
    end
  end

  assign busy         = (state_q == RUN);
  assign done         = (state_q == PASS) || (state_q == FAIL);
  assign pass         = (state_q == PASS);
  assign fail_code    = code_q;
  assign match_count  = match_q;
  assign cycle_count  = cycle_q;
  assign fail_address = faddr_q;
  assign fail_data    = fdata_q;

endmodule

// File: tb/tb_store_checker.sv
// Directed bench for store_checker with hand-computed expectations.
// Inputs are driven and outputs sampled 1 time unit after each rising edge.
module tb_store_checker;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int NE = 4;
  localparam int TO = 20;

  logic          clock = 1'b0;
  logic          reset_n;
  logic          load_valid;
  logic [AW-1:0] load_address;
  logic [DW-1:0] load_data;
  logic          start;
  logic          clear;
  logic          ordered;
  logic          memory_write_enable;
  logic [AW-1:0] data_memory_address;
  logic [DW-1:0] write_data;
  logic          load_full, busy, done, pass;
  logic [1:0]    fail_code;
  logic [$clog2(NE+1)-1:0] match_count;
  logic [$clog2(TO+1)-1:0] cycle_count;
  logic [AW-1:0] fail_address;
  logic [DW-1:0] fail_data;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clock = ~clock;

  store_checker #(
    .DATA_WIDTH     (DW),
    .ADDR_WIDTH     (AW),
    .NUM_EXPECT     (NE),
    .TIMEOUT_CYCLES (TO),
    .IGNORE_BASE    (96),
    .IGNORE_LIMIT   (96)
  ) dut (
    .clock               (clock),
    .reset_n             (reset_n),
    .load_valid          (load_valid),
    .load_address        (load_address),
    .load_data           (load_data),
    .start               (start),
    .clear               (clear),
    .ordered             (ordered),
    .memory_write_enable (memory_write_enable),
    .data_memory_address (data_memory_address),
    .write_data          (write_data),
    .load_full           (load_full),
    .busy                (busy),
    .done                (done),
    .pass                (pass),
    .fail_code           (fail_code),
    .match_count         (match_count),
    .cycle_count         (cycle_count),
    .fail_address        (fail_address),
    .fail_data           (fail_data)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic idle_inputs();
    load_valid          = 1'b0;
    load_address        = '0;
    load_data           = '0;
    start               = 1'b0;
    clear               = 1'b0;
    ordered             = 1'b1;
    memory_write_enable = 1'b0;
    data_memory_address = '0;
    write_data          = '0;
  endtask

  task automatic do_reset();
    idle_inputs();
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
  endtask

  task automatic load_entry(input logic [AW-1:0] a, input logic [DW-1:0] d);
    load_valid = 1'b1; load_address = a; load_data = d;
    tick();
    load_valid = 1'b0;
  endtask

  task automatic start_run();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic store_op(input logic [AW-1:0] a, input logic [DW-1:0] d);
    memory_write_enable = 1'b1; data_memory_address = a; write_data = d;
    tick();
    memory_write_enable = 1'b0;
  endtask

  task automatic clear_pulse();
    clear = 1'b1;
    tick();
    clear = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, ".load_full"},    load_full,    0);
    check({tag, ".busy"},         busy,         0);
    check({tag, ".done"},         done,         0);
    check({tag, ".pass"},         pass,         0);
    check({tag, ".fail_code"},    fail_code,    0);
    check({tag, ".match_count"},  match_count,  0);
    check({tag, ".cycle_count"},  cycle_count,  0);
    check({tag, ".fail_address"}, fail_address, 0);
    check({tag, ".fail_data"},    fail_data,    0);
  endtask

  initial begin
    idle_inputs();
    reset_n = 1'b0;
    tick();
    tick();
    check_all_zero("reset");
    reset_n = 1'b1;

    // Ignored scratch store then the expected store.
    load_entry(100, 7);
    check("t1.load_full", load_full, 0);
    start_run();
    check("t1.busy", busy, 1);
    check("t1.cycle0", cycle_count, 0);
    store_op(96, 3);
    check("t1.ign_busy", busy, 1);
    check("t1.ign_match", match_count, 0);
    store_op(100, 7);
    check("t1.pass", pass, 1);
    check("t1.done", done, 1);
    check("t1.match", match_count, 1);
    check("t1.cycle", cycle_count, 1);
    tick(); tick();
    check("t1.sticky", pass, 1);
    clear_pulse();
    check("t1.clr_done", done, 0);
    check("t1.clr_match", match_count, 0);
    check("t1.clr_cycle", cycle_count, 0);
    start_run();
    store_op(100, 7);
    check("t1.rerun_pass", pass, 1);

    // Ordered mode, out-of-order store.
    do_reset();
    load_entry(100, 7);
    load_entry(104, 9);
    start_run();
    store_op(104, 9);
    check("t2.done", done, 1);
    check("t2.pass", pass, 0);
    check("t2.code", fail_code, 1);
    check("t2.faddr", fail_address, 104);
    check("t2.fdata", fail_data, 9);
    store_op(100, 7);
    check("t2.sticky_code", fail_code, 1);
    check("t2.sticky_match", match_count, 0);
    clear_pulse();
    check("t2.clr_code", fail_code, 0);
    check("t2.clr_faddr", fail_address, 0);
    check("t2.clr_fdata", fail_data, 0);
    start_run();
    store_op(100, 7);
    store_op(104, 9);
    check("t2.rerun_pass", pass, 1);
    check("t2.rerun_match", match_count, 2);

    // Unordered mode only exists when the feature is built in.
    do_reset();
    ordered = 1'b0;
    load_entry(100, 7);
    load_entry(104, 9);
    start_run();
    store_op(104, 9);
`ifdef STORE_CHECKER_UNORDERED_EN
    check("t3.busy", busy, 1);
    check("t3.match1", match_count, 1);
    store_op(100, 7);
    check("t3.pass", pass, 1);
    check("t3.match2", match_count, 2);
    clear_pulse();
    start_run();
    store_op(104, 9);
    store_op(104, 9);
    check("t3.dup_code", fail_code, 1);
    check("t3.dup_faddr", fail_address, 104);
`else
    check("t3.ordered_only_code", fail_code, 1);
`endif
    ordered = 1'b1;

    // Timeout after exactly TO RUN cycles.
    do_reset();
    load_entry(100, 7);
    start_run();
    repeat (TO - 1) tick();
    check("t4.busy", busy, 1);
    check("t4.cycle_pre", cycle_count, TO - 1);
    tick();
    check("t4.code", fail_code, 2);
    check("t4.done", done, 1);
    check("t4.pass", pass, 0);
    check("t4.cycle", cycle_count, TO - 1);

    // Final match in the timeout cycle.
    do_reset();
    load_entry(100, 7);
    start_run();
    repeat (TO - 1) tick();
    store_op(100, 7);
    check("t5.pass", pass, 1);
    check("t5.code", fail_code, 0);
    check("t5.cycle", cycle_count, TO - 1);

    // Reset in the middle of a run.
    do_reset();
    load_entry(100, 7);
    load_entry(104, 9);
    start_run();
    store_op(100, 7);
    check("t6.match1", match_count, 1);
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    check_all_zero("t6.reset");
    load_entry(200, 5);
    start_run();
    store_op(200, 5);
    check("t6.pass", pass, 1);
    check("t6.match", match_count, 1);

    // Clear beats a simultaneous store.
    do_reset();
    load_entry(100, 7);
    start_run();
    clear = 1'b1; memory_write_enable = 1'b1; data_memory_address = 100; write_data = 7;
    tick();
    clear = 1'b0; memory_write_enable = 1'b0;
    check("t7.busy", busy, 0);
    check("t7.pass", pass, 0);
    check("t7.match", match_count, 0);
    start_run();
    store_op(100, 7);
    check("t7.rerun_pass", pass, 1);

    // Load with start is dropped: empty table passes immediately.
    do_reset();
    load_valid = 1'b1; load_address = 100; load_data = 7; start = 1'b1;
    tick();
    load_valid = 1'b0; start = 1'b0;
    check("t8.pass", pass, 1);
    check("t8.match", match_count, 0);

    // Full table drops the extra load.
    do_reset();
    for (int i = 0; i < NE; i++) load_entry(32'(10 + i), 32'(1 + i));
    check("t9.full", load_full, 1);
    load_entry(50, 50);
    start_run();
    for (int i = 0; i < NE; i++) store_op(32'(10 + i), 32'(1 + i));
    check("t9.pass", pass, 1);
    check("t9.match", match_count, NE);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/store_checker.md
Name: store_checker

Overview:
- Synthesizable self-checking monitor on the core's data-memory write port.
- Holds a table of NUM_EXPECT expected (address, data) stores and matches each non-ignored write against the table.
- Ignores writes inside a scratch address window.
- Reports pass, mismatch or timeout with captured diagnostics.
- Sits beside the top-level core in benches and FPGA builds; replaces hard-coded single-store success checks.

Parameters:
- DATA_WIDTH, 32, width of write data and expected data.
- ADDR_WIDTH, 32, width of memory address.
- NUM_EXPECT, 4, depth of expected-store table (>=1).
- TIMEOUT_CYCLES, 1000, RUN cycles allowed before timeout fail (>=1).
- IGNORE_BASE, 96, lowest ignored address (inclusive).
- IGNORE_LIMIT, 96, highest ignored address (inclusive); IGNORE_LIMIT < IGNORE_BASE disables the window.

Ports:
- clock  in  1  system clock.
- reset_n  in  1  synchronous active-low reset.
- load_valid  in  1  write one expected entry (IDLE only).
- load_address  in  ADDR_WIDTH  expected store address.
- load_data  in  DATA_WIDTH  expected store data.
- start  in  1  pulse; IDLE -> RUN.
- clear  in  1  pulse; PASS/FAIL/RUN -> IDLE.
- ordered  in  1  1 = entries must match in load order; 0 = any order.
- memory_write_enable  in  1  core store strobe.
- data_memory_address  in  ADDR_WIDTH  core store address.
- write_data  in  DATA_WIDTH  core store data.
- load_full  out  1  table holds NUM_EXPECT entries.
- busy  out  1  state == RUN.
- done  out  1  state is PASS or FAIL.
- pass  out  1  state == PASS.
- fail_code  out  2  0 none, 1 mismatch, 2 timeout.
- match_count  out  $clog2(NUM_EXPECT+1)  entries matched so far.
- cycle_count  out  $clog2(TIMEOUT_CYCLES+1)  RUN cycles elapsed; saturates.
- fail_address  out  ADDR_WIDTH  address of first offending store.
- fail_data  out  DATA_WIDTH  data of first offending store.

Behaviour:
- Reset: reset_n low at a posedge gives state IDLE, load pointer 0, all match flags 0, and every output 0. Applies from any state, including mid-RUN.
- States: IDLE, RUN, PASS, FAIL. All inputs are sampled at posedge; outputs are registered.
- IDLE, load:
  - load_valid with load pointer < NUM_EXPECT writes the entry and increments the pointer.
  - When full, the load is dropped.
  - load_valid together with start: the load is dropped.
- IDLE, start:
  - Enters RUN with cycle_count 0 and the ordered mode latched.
  - With zero entries loaded, goes directly to PASS.
- RUN, cycle counting:
  - cycle_count increments every RUN cycle.
  - At cycle_count == TIMEOUT_CYCLES-1 with entries still unmatched, goes to FAIL with fail_code 2.
- RUN, store handling on memory_write_enable:
  - Address inside [IGNORE_BASE, IGNORE_LIMIT]: ignored.
  - Ordered mode: compared with entry[match_count]. Equal address and data sets the flag and increments match_count. Otherwise goes to FAIL with fail_code 1 and captures fail_address/fail_data.
  - Unordered mode: matches the lowest-index unmatched entry with equal address and data. A duplicate of an already-matched entry with no other free match is a mismatch.
- Completion: PASS is entered the cycle after the final match.
- Simultaneous events:
  - Final match in the timeout cycle: PASS wins.
  - clear in the same cycle as a store: clear wins and the store is not checked.
- PASS and FAIL are sticky.
- clear returns to IDLE and zeroes match flags, counters, fail_* and fail_code. It retains table contents and the load pointer, so start reruns the same table; further loads append.
- clear in IDLE: no effect.
- start outside IDLE: ignored.

Optional Feature:
- Macro STORE_CHECKER_UNORDERED_EN.
- Defined: the ordered port selects the mode as above; a NUM_EXPECT-wide parallel comparator and priority encoder are built.
- Undefined: ordered mode only; the ordered port is ignored and only one comparator is built.

Decomposition:
- store_checker_pkg:
  - state_t enum (IDLE, RUN, PASS, FAIL).
  - fail_code_t enum (FAIL_NONE=0, FAIL_MISMATCH=1, FAIL_TIMEOUT=2).
- Sub-module store_match_table:
  - Entry registers, match flags, load pointer.
  - Ordered/unordered lookup, returning hit and index.
- The top level holds the FSM, counters and capture registers.

Test Plan:
- Load (100,7); start; stores (96,3) then (100,7) -> (96,3) ignored; pass=1, match_count=1 one cycle after the second store.
- Ordered mode; load (100,7),(104,9); stores (104,9) -> FAIL, fail_code=1, fail_address=104, fail_data=9.
- Unordered mode (macro defined); same load; stores (104,9),(100,7) -> PASS, match_count=2.
- TIMEOUT_CYCLES=20; load (100,7); no stores -> FAIL with fail_code=2 after exactly 20 RUN cycles; cycle_count=19.
- Final matching store in the timeout cycle -> PASS, fail_code=0.
- reset_n low for one cycle mid-RUN after 1 of 2 matches -> IDLE; all outputs 0; load_full=0. A new single-entry load then start and a matching store -> PASS.
